// File: rtl/laser_spot_locator.sv
// Luma-threshold laser spot centroid (SPOT_BBOX_EN adds a hit bounding box); spot_valid 30 cycles after frame_done rises.
// No backpressure: words arriving while the divider runs are dropped, words past the last pixel raise sticky overrun.
module laser_spot_locator #(
  parameter int H_WORDS   = 320,
  parameter int V_LINES   = 480,
  parameter int MIN_COUNT = 4
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [31:0] pixel_data,
  input  logic        pixel_done,
  input  logic        frame_done,
  input  logic [7:0]  y_thresh,
  output logic [9:0]  spot_x,
  output logic [8:0]  spot_y,
  output logic        spot_found,
  output logic        spot_valid,
  output logic [18:0] hit_count,
  output logic        busy,
`ifdef SPOT_BBOX_EN
  output logic [9:0]  bbox_x_min,
  output logic [9:0]  bbox_x_max,
  output logic [8:0]  bbox_y_min,
  output logic [8:0]  bbox_y_max,
`endif
  output logic        overrun
);
  localparam logic [8:0]  COL_LAST = 9'(H_WORDS - 1);
  localparam logic [8:0]  ROW_LAST = 9'(V_LINES - 1);
  localparam logic [18:0] MIN_CNT  = 19'(MIN_COUNT);

  typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;

  state_t      state;
  logic [8:0]  col, row;
  logic        full, prev_frame_done;
  logic [27:0] sum_x, sum_y;
  logic [18:0] cnt, rem_x, rem_y;
  logic [4:0]  iter;

  logic        hit0, hit1, frame_rise, accept;
  logic [9:0]  x0, x1, x_lo, x_hi;
  logic [27:0] add_x, add_y;
  logic [18:0] add_c;
  logic [19:0] tx, ty, dx, dy;
  logic        ge_x, ge_y, found, q_ok;
  logic        unused_bits;

`ifdef SPOT_BBOX_EN
  logic [9:0] run_x_min, run_x_max;
  logic [8:0] run_y_min, run_y_max;
`endif

  always_comb begin
    hit0       = pixel_data[31:24] >= y_thresh;
    hit1       = pixel_data[7:0] >= y_thresh;
    frame_rise = frame_done & ~prev_frame_done;
    accept     = pixel_done & ~full;
    x0         = {col, 1'b0};
    x1         = {col, 1'b1};
    x_lo       = hit0 ? x0 : x1;
    x_hi       = hit1 ? x1 : x0;
    add_x      = (hit0 ? 28'(x0) : 28'd0) + (hit1 ? 28'(x1) : 28'd0);
    add_y      = (hit0 ? 28'(row) : 28'd0) + (hit1 ? 28'(row) : 28'd0);
    add_c      = 19'(hit0) + 19'(hit1);
    // Restoring step: sum_x/sum_y shift out dividend bits and shift in quotient bits.
    tx         = {rem_x, sum_x[27]};
    ty         = {rem_y, sum_y[27]};
    dx         = tx - {1'b0, cnt};
    dy         = ty - {1'b0, cnt};
    ge_x       = tx >= {1'b0, cnt};
    ge_y       = ty >= {1'b0, cnt};
    found      = cnt >= MIN_CNT;
    q_ok       = found && (cnt != 19'd0);
  end

  assign unused_bits = ^{pixel_data[23:8], dx[19], dy[19]};

  always_ff @(posedge pclk) begin
    if (reset) begin
      state           <= ACCUM;
      col             <= '0;
      row             <= '0;
      full            <= 1'b0;
      prev_frame_done <= 1'b0;
      sum_x           <= '0;
      sum_y           <= '0;
      cnt             <= '0;
      rem_x           <= '0;
      rem_y           <= '0;
      iter            <= '0;
      spot_x          <= '0;
      spot_y          <= '0;
      spot_found      <= 1'b0;
      spot_valid      <= 1'b0;
      hit_count       <= '0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
`ifdef SPOT_BBOX_EN
      run_x_min       <= 10'd639;
      run_x_max       <= '0;
      run_y_min       <= 9'd479;
      run_y_max       <= '0;
      bbox_x_min      <= '0;
      bbox_x_max      <= '0;
      bbox_y_min      <= '0;
      bbox_y_max      <= '0;
`endif
    end else begin
      prev_frame_done <= frame_done;
      spot_valid      <= 1'b0;
      case (state)
        ACCUM: begin
          if (pixel_done && full) overrun <= 1'b1;
          if (accept) begin
            sum_x <= sum_x + add_x;
            sum_y <= sum_y + add_y;
            cnt   <= cnt + add_c;
`ifdef SPOT_BBOX_EN
            if (hit0 || hit1) begin
              if (x_lo < run_x_min) run_x_min <= x_lo;
              if (x_hi > run_x_max) run_x_max <= x_hi;
              if (row < run_y_min) run_y_min <= row;
              if (row > run_y_max) run_y_max <= row;
            end
`endif
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row  <= '0;
                full <= 1'b1;
              end else begin
                row <= row + 9'd1;
              end
            end else begin
              col <= col + 9'd1;
            end
          end
          if (frame_rise) begin
            state <= DIVIDE;
            busy  <= 1'b1;
            iter  <= '0;
            rem_x <= '0;
            rem_y <= '0;
          end
        end
        DIVIDE: begin
          sum_x <= {sum_x[26:0], ge_x};
          sum_y <= {sum_y[26:0], ge_y};
          rem_x <= ge_x ? dx[18:0] : tx[18:0];
          rem_y <= ge_y ? dy[18:0] : ty[18:0];
          iter  <= iter + 5'd1;
          if (iter == 5'd27) state <= DONE;
        end
        DONE: begin
          spot_found <= found;
          spot_x     <= q_ok ? sum_x[9:0] : 10'd0;
          spot_y     <= q_ok ? sum_y[8:0] : 9'd0;
          hit_count  <= cnt;
          spot_valid <= 1'b1;
          busy       <= 1'b0;
          sum_x      <= '0;
          sum_y      <= '0;
          cnt        <= '0;
          col        <= '0;
          row        <= '0;
          full       <= 1'b0;
`ifdef SPOT_BBOX_EN
          bbox_x_min <= found ? run_x_min : 10'd0;
          bbox_x_max <= found ? run_x_max : 10'd0;
          bbox_y_min <= found ? run_y_min : 9'd0;
          bbox_y_max <= found ? run_y_max : 9'd0;
          run_x_min  <= 10'd639;
          run_x_max  <= '0;
          run_y_min  <= 9'd479;
          run_y_max  <= '0;
`endif
          state      <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_laser_spot_locator.sv
// Directed frames on a reduced 128x64 geometry against two instances (MIN_COUNT 4 and 1) with a queued reference model.
module tb_laser_spot_locator;
  localparam int HW = 64;
  localparam int VL = 64;

  logic        pclk = 1'b0;
  logic        reset, pixel_done, frame_done;
  logic [31:0] pixel_data;
  logic [7:0]  y_thresh;

  logic [9:0]  spot_x_a, spot_x_b;
  logic [8:0]  spot_y_a, spot_y_b;
  logic        spot_found_a, spot_found_b, spot_valid_a, spot_valid_b;
  logic [18:0] hit_count_a, hit_count_b;
  logic        busy_a, busy_b, overrun_a, overrun_b;
`ifdef SPOT_BBOX_EN
  logic [9:0]  bx0_a, bx1_a, bx0_b, bx1_b;
  logic [8:0]  by0_a, by1_a, by0_b, by1_b;
`endif

  laser_spot_locator #(.H_WORDS(HW), .V_LINES(VL), .MIN_COUNT(4)) dut_a (
    .pclk(pclk), .reset(reset), .pixel_data(pixel_data), .pixel_done(pixel_done),
    .frame_done(frame_done), .y_thresh(y_thresh), .spot_x(spot_x_a), .spot_y(spot_y_a),
    .spot_found(spot_found_a), .spot_valid(spot_valid_a), .hit_count(hit_count_a),
    .busy(busy_a),
`ifdef SPOT_BBOX_EN
    .bbox_x_min(bx0_a), .bbox_x_max(bx1_a), .bbox_y_min(by0_a), .bbox_y_max(by1_a),
`endif
    .overrun(overrun_a));

  laser_spot_locator #(.H_WORDS(HW), .V_LINES(VL), .MIN_COUNT(1)) dut_b (
    .pclk(pclk), .reset(reset), .pixel_data(pixel_data), .pixel_done(pixel_done),
    .frame_done(frame_done), .y_thresh(y_thresh), .spot_x(spot_x_b), .spot_y(spot_y_b),
    .spot_found(spot_found_b), .spot_valid(spot_valid_b), .hit_count(hit_count_b),
    .busy(busy_b),
`ifdef SPOT_BBOX_EN
    .bbox_x_min(bx0_b), .bbox_x_max(bx1_b), .bbox_y_min(by0_b), .bbox_y_max(by1_b),
`endif
    .overrun(overrun_b));

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic        found;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [18:0] cnt;
    logic [9:0]  bx0, bx1;
    logic [8:0]  by0, by1;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model state
  int     m_col, m_row, m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
  longint m_sx, m_sy;
  bit     m_full, fd_q;

  task automatic model_clear();
    m_col = 0; m_row = 0; m_cnt = 0; m_sx = 0; m_sy = 0; m_full = 0;
    m_xmin = 639; m_xmax = 0; m_ymin = 479; m_ymax = 0;
  endtask

  task automatic model_hit(input int x);
    m_cnt++;
    m_sx += x;
    m_sy += m_row;
    if (x < m_xmin) m_xmin = x;
    if (x > m_xmax) m_xmax = x;
    if (m_row < m_ymin) m_ymin = m_row;
    if (m_row > m_ymax) m_ymax = m_row;
  endtask

  task automatic model_word(input logic [31:0] d);
    if (m_full) return;
    if (d[31:24] >= y_thresh) model_hit(2 * m_col);
    if (d[7:0] >= y_thresh) model_hit(2 * m_col + 1);
    if (m_col == HW - 1) begin
      m_col = 0;
      if (m_row == VL - 1) begin
        m_row = 0;
        m_full = 1;
      end else begin
        m_row++;
      end
    end else begin
      m_col++;
    end
  endtask

  function automatic exp_t make_exp(input int min_c);
    exp_t e;
    e.cyc   = cyc + 30;
    e.cnt   = 19'(m_cnt);
    e.found = (m_cnt >= min_c);
    if (e.found) begin
      e.x = 10'(m_sx / m_cnt);
      e.y = 9'(m_sy / m_cnt);
      e.bx0 = 10'(m_xmin); e.bx1 = 10'(m_xmax);
      e.by0 = 9'(m_ymin);  e.by1 = 9'(m_ymax);
    end else begin
      e.x = '0; e.y = '0; e.bx0 = '0; e.bx1 = '0; e.by0 = '0; e.by1 = '0;
    end
    return e;
  endfunction

  task automatic step(input logic pd, input logic [31:0] d, input logic fd);
    pixel_done = pd;
    pixel_data = d;
    frame_done = fd;
    if (pd) model_word(d);
    if (fd && !fd_q) begin
      q_a.push_back(make_exp(4));
      q_b.push_back(make_exp(1));
      model_clear();
    end
    fd_q = fd;
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [31:0] word_for(input int mode, input int r, input int c);
    logic [31:0] w;
    w = 32'h0080_8000;
    case (mode)
      1: if (c == 50 && (r == 50 || r == 51)) w = 32'hFF80_80FF;
      2: w = 32'hFF80_80FF;
      3: if (c == 10 && r == 5) w = {8'd200, 8'h80, 8'h80, 8'd199};
      default: w = 32'h0080_8000;
    endcase
    return w;
  endfunction

  task automatic wait_done();
    check("busy_dividing", 32'(busy_a), 32'd1);
    for (int i = 0; i < 60 && (q_a.size() + q_b.size()) != 0; i++) step(1'b0, 32'h0, 1'b1);
    check("result_timeout", 32'(q_a.size() + q_b.size()), 32'd0);
    q_a.delete();
    q_b.delete();
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
  endtask

  // rise_mode: 0 separate rise, 1 rise with last word, 2 separate rise without waiting
  task automatic run_frame(input int mode, input int rise_mode, input int extra);
    for (int r = 0; r < VL; r++)
      for (int c = 0; c < HW; c++)
        step(1'b1, word_for(mode, r, c), (rise_mode == 1) && r == VL - 1 && c == HW - 1);
    for (int i = 0; i < extra; i++) step(1'b1, 32'hFF80_80FF, 1'b0);
    if (rise_mode != 1) step(1'b0, 32'h0, 1'b1);
    if (rise_mode != 2) wait_done();
  endtask

  exp_t ea, eb;
  always @(negedge pclk) begin
    if (spot_valid_a) begin
      if (q_a.size() == 0) check("extra_valid_a", 32'(spot_valid_a), 32'd0);
      else begin
        ea = q_a.pop_front();
        check("latency_a", cyc, ea.cyc);
        check("found_a", 32'(spot_found_a), 32'(ea.found));
        check("spot_x_a", 32'(spot_x_a), 32'(ea.x));
        check("spot_y_a", 32'(spot_y_a), 32'(ea.y));
        check("hit_count_a", 32'(hit_count_a), 32'(ea.cnt));
        check("busy_done_a", 32'(busy_a), 32'd0);
`ifdef SPOT_BBOX_EN
        check("bbox_x_min_a", 32'(bx0_a), 32'(ea.bx0));
        check("bbox_x_max_a", 32'(bx1_a), 32'(ea.bx1));
        check("bbox_y_min_a", 32'(by0_a), 32'(ea.by0));
        check("bbox_y_max_a", 32'(by1_a), 32'(ea.by1));
`endif
      end
    end
    if (spot_valid_b) begin
      if (q_b.size() == 0) check("extra_valid_b", 32'(spot_valid_b), 32'd0);
      else begin
        eb = q_b.pop_front();
        check("latency_b", cyc, eb.cyc);
        check("found_b", 32'(spot_found_b), 32'(eb.found));
        check("spot_x_b", 32'(spot_x_b), 32'(eb.x));
        check("spot_y_b", 32'(spot_y_b), 32'(eb.y));
        check("hit_count_b", 32'(hit_count_b), 32'(eb.cnt));
`ifdef SPOT_BBOX_EN
        check("bbox_x_min_b", 32'(bx0_b), 32'(eb.bx0));
        check("bbox_x_max_b", 32'(bx1_b), 32'(eb.bx1));
        check("bbox_y_min_b", 32'(by0_b), 32'(eb.by0));
        check("bbox_y_max_b", 32'(by1_b), 32'(eb.by1));
`endif
      end
    end
  end

  initial begin
    reset = 1'b1; pixel_done = 1'b0; frame_done = 1'b0; pixel_data = '0; y_thresh = 8'd200;
    fd_q = 0;
    model_clear();
    repeat (3) step(1'b0, 32'h0, 1'b0);
    check("rst_spot_x", 32'(spot_x_a), 32'd0);
    check("rst_spot_y", 32'(spot_y_a), 32'd0);
    check("rst_found", 32'(spot_found_a), 32'd0);
    check("rst_valid", 32'(spot_valid_a), 32'd0);
    check("rst_hit_count", 32'(hit_count_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_overrun", 32'(overrun_a), 32'd0);
    reset = 1'b0;
    step(1'b0, 32'h0, 1'b0);

    run_frame(0, 0, 0);   // dark frame
    run_frame(1, 1, 0);   // 2x2 spot, rise coincides with last word
    run_frame(2, 1, 0);   // whole frame lit, last word counted with the rise
    check("no_overrun_full_frame", 32'(overrun_a), 32'd0);
    run_frame(3, 0, 0);   // single word: below MIN_COUNT on a, found on b

    // Abort a division with reset
    run_frame(1, 2, 0);
    q_a.delete();
    q_b.delete();
    repeat (10) step(1'b0, 32'h0, 1'b1);
    check("busy_before_abort", 32'(busy_a), 32'd1);
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    check("busy_after_abort", 32'(busy_a), 32'd0);
    check("valid_after_abort", 32'(spot_valid_a), 32'd0);
    check("hit_count_after_abort", 32'(hit_count_b), 32'd0);
    check("spot_x_after_abort", 32'(spot_x_b), 32'd0);
    reset = 1'b0;
    fd_q = 0;
    model_clear();
    repeat (40) step(1'b0, 32'h0, 1'b0);
    run_frame(1, 0, 0);

    // One word beyond the frame
    run_frame(1, 0, 1);
    check("overrun_a", 32'(overrun_a), 32'd1);
    check("overrun_b", 32'(overrun_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/laser_spot_locator.md
Name: laser_spot_locator

Overview:
- Sits directly downstream of the camera capture stage, on the same pclk domain.
- Consumes the 32-bit YCbCr422 pixel-pair words and their pixel_done strobes, then thresholds luma (Y0, Y1) to find laser-lit pixels.
- Accumulates x/y coordinate sums and a hit count over one frame.
- On the rising edge of frame_done, runs a multi-cycle serial division and reports the spot centroid to the game logic.

Parameters:
- H_WORDS, 320: pixel-pair words per line (640 px).
- V_LINES, 480: lines per frame.
- MIN_COUNT, 4: minimum hit pixels for a valid spot.

Ports:
- pclk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pixel_data  in  32  {Y0[31:24], Cb[23:16], Cr[15:8], Y1[7:0]}.
- pixel_done  in  1  one-cycle strobe; pixel_data is valid that cycle.
- frame_done  in  1  level; goes high once the capture stage has finished the frame.
- y_thresh  in  8  luma threshold; compared unsigned, hit when Y >= y_thresh.
- spot_x  out  10  centroid column, 0..639.
- spot_y  out  9  centroid row, 0..479.
- spot_found  out  1  hit count >= MIN_COUNT on the last frame.
- spot_valid  out  1  one-cycle pulse when spot_x, spot_y and spot_found update.
- hit_count  out  19  hits counted in the last completed frame.
- busy  out  1  high while dividing.
- overrun  out  1  sticky; a word arrived after the last pixel of the frame.

Behaviour:
- Reset, synchronous: all outputs 0; sums, counters, col, row and prev_frame_done cleared; state = ACCUM. Reset in any state aborts the state immediately and suppresses spot_valid.
- Position tracking:
  - col (0..H_WORDS-1) and row (0..V_LINES-1) advance on each pixel_done.
  - col wraps to 0 and row increments at H_WORDS-1.
  - Pixel x = 2*col for Y0 and 2*col+1 for Y1; pixel y = row.
- Accumulators (widths fixed, no overflow possible at 640x480):
  - sum_x: 28 bits.
  - sum_y: 28 bits.
  - cnt: 19 bits.
- Per word, each of Y0 and Y1 is tested independently, so a word adds 0, 1 or 2 hits in one cycle.
  - sum_x += x of each hit.
  - sum_y += row per hit.
  - cnt += number of hits.
- After the word at row V_LINES-1, col H_WORDS-1, any further pixel_done sets overrun and leaves sums unchanged.
- State ACCUM:
  - Accumulate as above.
  - frame_rise = frame_done & ~prev_frame_done.
  - On frame_rise: go to DIVIDE and set busy = 1. A pixel_done in that same cycle is still accumulated and is included in the division.
- State DIVIDE:
  - Two restoring dividers run in parallel: sum_x/cnt and sum_y/cnt, 28 iterations, one per cycle.
  - Quotients are floor. If cnt == 0, quotients are forced to 0 (no divide-by-zero).
  - Then go to DONE.
  - pixel_done is ignored here.
- State DONE, one cycle:
  - spot_found = (cnt >= MIN_COUNT).
  - spot_x/spot_y = quotients if found, else 0.
  - hit_count = cnt; spot_valid = 1; busy = 0.
  - Clear sums, cnt, col and row. Go to ACCUM.
- Latency: spot_valid is high exactly 30 cycles after the cycle in which frame_rise is sampled (1 transition + 28 iterations + DONE).
- Outputs hold between spot_valid pulses.
- frame_done stays high; there is no re-trigger until it falls and rises again, or until reset.

Optional Feature:
- Macro: SPOT_BBOX_EN.
- Defined:
  - Adds outputs bbox_x_min[9:0], bbox_x_max[9:0], bbox_y_min[8:0], bbox_y_max[8:0].
  - Running min/max are tracked over hit pixels during ACCUM.
  - Latched in DONE together with spot_valid.
  - When spot_found = 0, all four report 0.
  - Running min resets to 639/479; running max resets to 0; outputs reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Frame of all Y=0, y_thresh=200, then frame_done rises -> spot_valid once, 30 cycles later; spot_found=0, spot_x=0, spot_y=0, hit_count=0.
- Y0=Y1=255 at col 50, rows 50 and 51 (pixels x=100,101), elsewhere 0 -> hit_count=4, spot_found=1, spot_x=100 (402/4 floored), spot_y=50. With SPOT_BBOX_EN: x 100..101, y 50..51.
- Whole frame Y=255 -> hit_count=307200, spot_x=319, spot_y=239 (exercises full 28-bit sums).
- Single word at col 10, row 5 with Y0=200, Y1=199, y_thresh=200, MIN_COUNT=4 -> hit_count=1, spot_found=0, spot_x=0. Same stimulus with MIN_COUNT=1 -> spot_x=20, spot_y=5.
- Assert reset 10 cycles into DIVIDE -> busy=0 next cycle, no spot_valid. A following frame with the 2x2 spot gives the correct result.
- Send 153601 pixel_done strobes, the extra word at Y=255 -> overrun=1; sums exclude the extra word; centroid unchanged versus the 153600-word frame.
